// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx between NUM_REQ byte producers using round-robin
//   arbitration. When uart_tx is ready, the winning requester's byte is
//   captured, a one-cycle start pulse is issued, and the requester receives a
//   one-cycle ack in the same cycle. The block then waits for tx_ready to fall
//   (bounded by BUSY_TIMEOUT) and to rise again before arbitrating next.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   BUSY_TIMEOUT  max cycles to wait for tx_ready to fall after tx_start (4..255)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   per-requester byte available, held until its ack
//   req_data   in   byte i at [8*i+7:8*i]
//   req_lock   in   (UART_ARB_LOCK_EN only) keep the grant on the last winner
//   req_ack    out  one-cycle pulse, byte of requester i consumed
//   tx_start   out  one-cycle start pulse to uart_tx
//   tx_data    out  byte to uart_tx, held until the next grant
//   tx_ready   in   uart_tx ready/idle level
//   gnt_id     out  index of the current/last granted requester
//   busy       out  high whenever the FSM is not in IDLE
//   tmo_err    out  one-cycle pulse when tx_ready never fell after tx_start
//
// Configuration
//   UART_ARB_LOCK_EN  when defined, adds req_lock: a locked and valid last
//                     winner is granted again, overriding round-robin.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 tmo_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [7:0]           timer_q, timer_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [2:0]           gnt_id_q, gnt_id_d;
  logic                 busy_q, busy_d;
  logic                 tmo_err_q, tmo_err_d;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic [7:0]           req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin search starts just after the last winner, so the last winner
  // is only picked again when nobody else is valid.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef UART_ARB_LOCK_EN
    // A locked last winner keeps the channel so its packet is not interleaved.
    if (req_lock[last_q] && req_valid[last_q]) begin
      win_found = 1'b1;
      win_idx   = last_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    gnt_id_d   = gnt_id_q;
    tmo_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_ready && win_found) begin
          tx_data_d          = req_bytes[win_idx];
          tx_start_d         = 1'b1;
          req_ack_d[win_idx] = 1'b1;
          gnt_id_d           = 3'(win_idx);
          last_d             = win_idx;
          timer_d            = 8'd0;
          state_d            = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        timer_d = timer_q + 8'd1;
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (timer_q == 8'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never acknowledged the start; give up on this byte.
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IW'(NUM_REQ - 1);
      timer_q    <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      req_ack_q  <= '0;
      gnt_id_q   <= 3'd0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      req_ack_q  <= req_ack_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign tmo_err  = tmo_err_q;

endmodule
